// File: rtl/sub_serial.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
// Start/busy/done handshake with borrow-out and signed-overflow flags.
module sub_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gen_bad_param
    $fatal(1, "sub_serial: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [DIGIT-1:0]  a_dig, b_dig, dig_diff;
  logic              dig_borrow;

  assign a_dig = a_q[cnt_q*DIGIT +: DIGIT];
  assign b_dig = b_q[cnt_q*DIGIT +: DIGIT];

  // MSB of the (DIGIT+1)-bit difference is the borrow out of this digit.
  assign {dig_borrow, dig_diff} = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        diff_d[cnt_q*DIGIT +: DIGIT] = dig_diff;
        borrow_d = dig_borrow;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          bout_d  = dig_borrow;
          // Equivalent to borrow-in XOR borrow-out at the sign bit.
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (dig_diff[DIGIT-1] ^ a_q[WIDTH-1]);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed cases plus a random sweep over DIGIT = 4, 1, 8, 16
// compared against an integer-arithmetic reference model.
module tb_sub_serial;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a, b;
  logic          bin;
  logic          busy [4];
  logic          done [4];
  logic [W-1:0]  diff [4];
  logic          bout [4];
  logic          ovf  [4];

  int lat_exp [4] = '{4, 16, 2, 1};
  int dig_of  [4] = '{4, 1, 8, 16};
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sub_serial #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy[0]), .done(done[0]), .diff(diff[0]), .bout(bout[0]), .ovf(ovf[0])
  );
  sub_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy[1]), .done(done[1]), .diff(diff[1]), .bout(bout[1]), .ovf(ovf[1])
  );
  sub_serial #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy[2]), .done(done[2]), .diff(diff[2]), .bout(bout[2]), .ovf(ovf[2])
  );
  sub_serial #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy[3]), .done(done[3]), .diff(diff[3]), .bout(bout[3]), .ovf(ovf[3])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    int ua, ub, sa, sb, r;
    ua = int'(va);
    ub = int'(vb);
    sa = int'($signed(va));
    sb = int'($signed(vb));
    d  = W'(ua - ub - int'(vbin));
    bo = (ua < ub + int'(vbin));
    r  = sa - sb - int'(vbin);
    ov = (r > 32767) || (r < -32768);
  endfunction

  // Pulse start for one edge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
    @(negedge clk);
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic op_all(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                        input string tag);
    int lat [4];
    int nd  [4];
    int nbusy;
    logic [W-1:0] ed;
    logic eb, eo;
    launch(va, vb, vbin);
    for (int i = 0; i < 4; i++) begin lat[i] = 0; nd[i] = 0; end
    nbusy = busy[0] ? 1 : 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (busy[0]) nbusy++;
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          nd[i]++;
          if (lat[i] == 0) lat[i] = e;
        end
      end
    end
    model(va, vb, vbin, ed, eb, eo);
    check($sformatf("%s busy_cycles d4", tag), 32'(nbusy), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s latency d%0d", tag, dig_of[i]), 32'(lat[i]), 32'(lat_exp[i]));
      check($sformatf("%s done_count d%0d", tag, dig_of[i]), 32'(nd[i]), 32'd1);
      check($sformatf("%s diff d%0d", tag, dig_of[i]), 32'(diff[i]), 32'(ed));
      check($sformatf("%s bout d%0d", tag, dig_of[i]), 32'(bout[i]), 32'(eb));
      check($sformatf("%s ovf d%0d", tag, dig_of[i]), 32'(ovf[i]), 32'(eo));
    end
  endtask

  initial begin
    logic [W-1:0] ed, va, vb;
    logic eb, eo;
    int nd, e;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset outs d%0d", dig_of[i]),
            {busy[i], done[i], bout[i], ovf[i], 12'h0, diff[i]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic, borrow ripple and overflow cases
    op_all(16'h1234, 16'h0234, 1'b0, "t1");
    check("t1 diff const", 32'(diff[0]), 32'h1000);
    op_all(16'h0000, 16'h0001, 1'b0, "t2a");
    op_all(16'h0000, 16'h0000, 1'b1, "t2b");
    check("t2b diff const", 32'(diff[0]), 32'hFFFF);
    op_all(16'h8000, 16'h0001, 1'b0, "t3a");
    check("t3a ovf const", 32'(ovf[0]), 32'h1);
    op_all(16'h7FFF, 16'hFFFF, 1'b0, "t3b");
    check("t3b diff const", 32'(diff[0]), 32'h8000);

    // Asynchronous reset between edges while digit 2 is pending
    launch(16'hABCD, 16'h1234, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 busy after reset", 32'(busy[0]), 32'h0);
    check("t5 done after reset", 32'(done[0]), 32'h0);
    check("t5 diff after reset", 32'(diff[0]), 32'h0);
    check("t5 bout after reset", 32'(bout[0]), 32'h0);
    check("t5 ovf after reset", 32'(ovf[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    check("t5 no done after abort", 32'(nd), 32'h0);
    op_all(16'hABCD, 16'h1234, 1'b0, "t5 fresh");

    // Start during RUN is ignored
    launch(16'h5555, 16'h1111, 1'b0);
    a = 16'hFFFF; b = 16'h0000; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h1234;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    check("t4 single done", 32'(nd), 32'h1);
    check("t4 diff", 32'(diff[0]), 32'h4444);

    // Back-to-back: start held on the done cycle
    launch(16'h9ABC, 16'h1357, 1'b0);
    e = 1;
    while (!done[0] && e < 20) begin
      @(negedge clk);
      e++;
    end
    check("t4 b2b first done", 32'(done[0]), 32'h1);
    model(16'h9ABC, 16'h1357, 1'b0, ed, eb, eo);
    check("t4 b2b first diff", 32'(diff[0]), 32'(ed));
    a = 16'h0F0F; b = 16'hF0F0; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4 b2b done cleared", 32'(done[0]), 32'h0);
    check("t4 b2b accepted", 32'(busy[0]), 32'h1);
    e = 0;
    while (!done[0] && e < 20) begin
      @(negedge clk);
      e++;
    end
    check("t4 b2b latency", 32'(e), 32'd4);
    model(16'h0F0F, 16'hF0F0, 1'b1, ed, eb, eo);
    check("t4 b2b diff", 32'(diff[0]), 32'(ed));
    check("t4 b2b bout", 32'(bout[0]), 32'(eb));
    repeat (20) @(negedge clk);

    // Random sweep across all DIGIT settings
    for (int v = 0; v < 1000; v++) begin
      case ($urandom_range(0, 7))
        0: va = 16'h0000;
        1: va = 16'hFFFF;
        2: va = 16'h8000;
        3: va = 16'h7FFF;
        default: va = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: vb = 16'h0000;
        1: vb = 16'hFFFF;
        2: vb = 16'h8000;
        3: vb = va;
        default: vb = W'($urandom);
      endcase
      op_all(va, vb, 1'($urandom), $sformatf("rnd%0d", v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Multi-cycle, digit-serial subtractor computing diff = a - b - bin over a parametrised operand width.
- Processes DIGIT bits per clock, LSB digit first, and carries the borrow between cycles in a register.
- Trades latency for area against the full-width ripple subtractors in the arithmetic library.
- Uses a start/busy/done handshake and adds signed-overflow reporting, which the fixed-width subtractors lack.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be >= 1.
- DIGIT, 4, bits processed per cycle. Must be >= 1, <= WIDTH, and WIDTH % DIGIT == 0; otherwise elaboration fails.
- Derived: N = WIDTH/DIGIT, the number of digit cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when results are valid
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow-out (unsigned a < b + bin)
ovf  output  1  signed two's-complement overflow

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0. Internal operand registers, digit counter and borrow register are all cleared.
- FSM states: IDLE, RUN. done is a registered flag, not a separate state.
- IDLE: on a rising edge with start=1:
  - capture a, b, bin;
  - set the borrow register to bin and the digit counter to 0;
  - go to RUN, busy=1.
  - done is cleared on this same edge.
- RUN, each edge, for digit i = counter:
  - compute {borrow_next, d} = a[i*DIGIT +: DIGIT] - b[i*DIGIT +: DIGIT] - borrow;
  - write d into diff[i*DIGIT +: DIGIT] and register borrow_next;
  - increment the counter.
- On the edge processing digit N-1:
  - bout = final borrow;
  - ovf = (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1);
  - done=1, busy=0, state goes to IDLE.
- Latency: done is high in the cycle starting N edges after the accepting edge. With DIGIT=WIDTH, N=1.
- done is high for exactly one cycle. It clears on the next edge unless a new start is accepted on that edge, in which case it also clears.
- diff, bout and ovf hold after done until the next accepted start.
  - During RUN, diff is partially updated and must not be consumed.
  - bout and ovf keep their previous values until the final edge.
- Back-to-back operation: start=1 on the edge where done is high is accepted (the state is IDLE). Throughput is one result per N+1 cycles.
- start during RUN is ignored and not queued. a, b and bin changes during RUN have no effect.
- Reset mid-operation aborts immediately with all outputs zero. No done is produced for the aborted operation.
- Arithmetic is unsigned modulo 2^WIDTH. bout=1 iff a < b + bin (unsigned). ovf is meaningful only when operands are interpreted as signed.

Test Plan:
1. WIDTH=16, DIGIT=4; a=0x1234, b=0x0234, bin=0, start pulse -> busy=1 for 4 cycles; done pulse 4 cycles after start edge; diff=0x1000, bout=0, ovf=0.
2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1; borrow ripples through all digits.
3. a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
4. Start a=0x5555, b=0x1111; pulse start again with a=0xFFFF mid-RUN and change the inputs -> second start ignored; result 0x4444; exactly one done. Then start held high on the done cycle -> next operation accepted; done again 4 cycles later.
5. rst_n low for 1 cycle asynchronously (between edges) during RUN digit 2 -> outputs 0 immediately, busy=0, no done. A fresh start afterwards gives a correct result.
6. Parameter sweep DIGIT=1, 8, 16 with WIDTH=16, random 1000 vectors against a reference model -> latency equals N; diff, bout and ovf match.
